// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one iterative AES-128 encipher core between NUM_REQ
// requesters. It loads round keys into the core and holds off encryption until
// every round 1..AES_ROUNDS has a key. Block requests are granted round-robin,
// and each ciphertext is returned tagged with the id of its requester.
// Optional build macro: AES_ARB_TIMEOUT_EN adds a BUSY watchdog of TIMEOUT cycles.
module aes_core_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int AES_ROUNDS = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_block,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [127:0]           rsp_data,
    output logic                   rsp_err,
    input  logic                   key_wr_valid,
    output logic                   key_wr_ready,
    input  logic [3:0]             key_wr_round,
    input  logic [127:0]           key_wr_data,
    output logic                   keys_ready,
    output logic                   core_next,
    output logic [127:0]           core_block,
    output logic [3:0]             core_init_round,
    output logic [127:0]           core_init_roundkey,
    output logic                   core_init_roundkey_valid,
    input  logic [127:0]           core_result,
    input  logic                   core_result_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]            r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_gid;
    logic [AES_ROUNDS-1:0] r_key_loaded;
    logic                  r_keys_ready;
    logic [127:0]          r_block;
    logic [127:0]          r_rsp_data;

    logic                  w_idle;
    logic                  w_issue;
    logic                  w_busy;
    logic                  w_resp;
    logic                  w_round_ok;
    logic                  w_key_acc;
    logic                  w_key_stb;
    logic [AES_ROUNDS-1:0] w_loaded_next;
    logic                  w_gnt_hit;
    logic [ID_W-1:0]       w_gnt_id;
    logic [ID_W-1:0]       w_idx;
    logic                  w_grant;
    logic                  w_tmo;

    // Every state decode is qualified by rst so all outputs read 0 while reset is held.
    assign w_idle  = rst && (r_state == S_IDLE);
    assign w_issue = rst && (r_state == S_ISSUE);
    assign w_busy  = rst && (r_state == S_BUSY);
    assign w_resp  = rst && (r_state == S_RESP);

    // Key writes are only taken in IDLE; out-of-range rounds are accepted and dropped.
    assign w_round_ok    = (key_wr_round != 4'd0) && (key_wr_round <= 4'(AES_ROUNDS));
    assign w_key_acc     = w_idle && key_wr_valid;
    assign w_key_stb     = w_key_acc && w_round_ok;
    assign w_loaded_next = w_key_stb ? (r_key_loaded | (AES_ROUNDS'(1) << (key_wr_round - 4'd1)))
                                     : r_key_loaded;

    // Round-robin search: first valid requester at or above r_rr_ptr, wrapping around.
    always_comb begin
        w_gnt_hit = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_gnt_hit && req_valid[w_idx]) begin
                w_gnt_hit = 1'b1;
                w_gnt_id  = w_idx;
            end
        end
    end

    // A key write in the same IDLE cycle wins over any block request.
    assign w_grant   = w_idle && !key_wr_valid && r_keys_ready && w_gnt_hit;
    assign req_ready = w_grant ? (NUM_REQ'(1) << w_gnt_id) : '0;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_rsp_err;

    // The last BUSY cycle of the watchdog window gives up unless the core answers in it.
    assign w_tmo = w_busy && !core_result_valid && (r_tmo_cnt == CNT_W'(TIMEOUT - 1));

    // Watchdog counter restarts on the way into BUSY; the error flag lives until the handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tmo_cnt <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_tmo_cnt <= '0;
            end else if (w_busy) begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end
            if (w_tmo) begin
                r_rsp_err <= 1'b1;
            end else if (w_resp && rsp_ready) begin
                r_rsp_err <= 1'b0;
            end
        end
    end

    assign rsp_err = w_resp && r_rsp_err;
`else
    // TIMEOUT only matters when the watchdog is compiled in.
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT > 0);
    assign w_tmo        = 1'b0;
    assign rsp_err      = 1'b0;
`endif

    // Control state: job sequencing, round-robin pointer and the loaded-key mask.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_key_loaded <= '0;
            r_keys_ready <= 1'b0;
        end else begin
            r_key_loaded <= w_loaded_next;
            r_keys_ready <= &w_loaded_next;
            case (r_state)
                S_IDLE:  if (w_grant) r_state <= S_ISSUE;
                S_ISSUE: r_state <= S_BUSY;
                S_BUSY:  if (core_result_valid || w_tmo) r_state <= S_RESP;
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state  <= S_IDLE;
                        r_rr_ptr <= (r_gid == ID_W'(NUM_REQ - 1)) ? '0 : r_gid + ID_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath captures: granted id and plaintext, then the core's ciphertext.
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_gid   <= w_gnt_id;
            r_block <= req_block[w_gnt_id*128 +: 128];
        end
        if (w_busy) begin
            if (core_result_valid) begin
                r_rsp_data <= core_result;
            end else if (w_tmo) begin
                r_rsp_data <= '0;
            end
        end
    end

    assign key_wr_ready             = w_key_acc;
    assign core_init_roundkey_valid = w_key_stb;
    assign core_init_round          = w_key_stb ? key_wr_round : 4'd0;
    assign core_init_roundkey       = w_key_stb ? key_wr_data : '0;
    assign keys_ready               = r_keys_ready;
    assign core_next                = w_issue;
    assign core_block               = (w_issue || w_busy) ? r_block : '0;
    assign rsp_valid                = w_resp;
    assign rsp_id                   = w_resp ? r_gid : '0;
    assign rsp_data                 = w_resp ? r_rsp_data : '0;

endmodule
